// File: rtl/saturn_bus_program_reader_pkg.sv
// rtl/saturn_bus_program_reader_pkg.sv - bus command codes and reader state encodings
package saturn_bus_program_reader_pkg;

  // Saturn bus command nibbles carried by {is_cmd=1, nibble} program entries
  localparam logic [3:0] BUSCMD_NOP     = 4'h0;
  localparam logic [3:0] BUSCMD_PC_READ = 4'h2;
  localparam logic [3:0] BUSCMD_DP_READ = 4'h3;
  localparam logic [3:0] BUSCMD_LOAD_PC = 4'h6;
  localparam logic [3:0] BUSCMD_LOAD_DP = 4'h7;

  // ERROR_IDLE is a reserved encoding; the reader treats it exactly like IDLE
  typedef enum logic [1:0] {
    READER_ST_IDLE        = 2'd0,
    READER_ST_SEND_ADDR   = 2'd1,
    READER_ST_READ_STREAM = 2'd2,
    READER_ST_ERROR_IDLE  = 2'd3
  } reader_state_e;

endpackage

// File: rtl/saturn_bus_program_reader.sv
// rtl/saturn_bus_program_reader.sv - replays bus program entries onto the Saturn nibble bus
// Optional feature macro: SATURN_BUS_AUTO_PC_READ_EN (emit PC_READ after the last LOAD_PC address nibble)
module saturn_bus_program_reader
  import saturn_bus_program_reader_pkg::*;
#(
  parameter int PROG_AW      = 5,
  parameter int ADDR_NIBBLES = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clk_en,
  input  logic [3:0]         i_phases,
  input  logic [1:0]         i_phase,
  input  logic [31:0]        i_cycle_ctr,
  input  logic [4:0]         i_program_data,
  input  logic [PROG_AW-1:0] i_program_address,
  output logic [PROG_AW-1:0] o_program_address,
  input  logic               i_no_read,
  output logic               o_bus_busy,
  output logic               o_bus_strobe,
  output logic               o_bus_cmd_data,
  output logic [3:0]         o_bus_nibble,
  input  logic [3:0]         i_bus_nibble,
  output logic [3:0]         o_nibble,
  output logic               o_nibble_valid,
  output logic               o_error
);

  localparam int            CW       = (ADDR_NIBBLES > 1) ? $clog2(ADDR_NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ADDR_NIBBLES - 1);

  reader_state_e      state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PROG_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic               strobe_q, strobe_d;
  logic               cmd_data_q, cmd_data_d;
  logic [3:0]         bus_nibble_q, bus_nibble_d;
  logic               read_wait_q, read_wait_d;
  logic [3:0]         nibble_q, nibble_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic               busy_q, busy_d;
`ifdef SATURN_BUS_AUTO_PC_READ_EN
  logic               is_pc_q, is_pc_d;
  logic               auto_pend_q, auto_pend_d;
`endif

  logic       entry_cmd;
  logic [3:0] entry_nib;
  logic       empty;
  logic       slot;
  logic       unused_trace;

  assign entry_cmd    = i_program_data[4];
  assign entry_nib    = i_program_data[3:0];
  assign empty        = (rd_ptr_q == i_program_address);
  assign slot         = i_clk_en & i_phases[0];
  assign unused_trace = ^{i_phase, i_cycle_ctr, i_phases[3], i_phases[1]};

  // Next-state: at most one entry per bus slot, read strobes fill empty read-stream slots
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    strobe_d     = strobe_q;
    cmd_data_d   = cmd_data_q;
    bus_nibble_d = bus_nibble_q;
    read_wait_d  = read_wait_q;
    nibble_d     = nibble_q;
    valid_d      = valid_q;
    error_d      = error_q;
    busy_d       = busy_q;
`ifdef SATURN_BUS_AUTO_PC_READ_EN
    is_pc_d      = is_pc_q;
    auto_pend_d  = auto_pend_q;
`endif
    if (i_clk_en) begin
      strobe_d = 1'b0;
      valid_d  = 1'b0;
      // the bus answers a read strobe two phases later
      if (i_phases[2] && read_wait_q) begin
        nibble_d    = i_bus_nibble;
        valid_d     = 1'b1;
        read_wait_d = 1'b0;
      end
      if (slot) begin
        case (state_q)
          READER_ST_SEND_ADDR: begin
`ifdef SATURN_BUS_AUTO_PC_READ_EN
            if (auto_pend_q) begin
              strobe_d     = 1'b1;
              cmd_data_d   = 1'b1;
              bus_nibble_d = BUSCMD_PC_READ;
              state_d      = READER_ST_READ_STREAM;
              auto_pend_d  = 1'b0;
            end else
`endif
            if (!empty) begin
              if (entry_cmd) begin
                // command arriving mid-address is left in the buffer
                error_d = 1'b1;
                state_d = READER_ST_IDLE;
              end else begin
                rd_ptr_d     = rd_ptr_q + PROG_AW'(1);
                strobe_d     = 1'b1;
                cmd_data_d   = 1'b0;
                bus_nibble_d = entry_nib;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef SATURN_BUS_AUTO_PC_READ_EN
                  if (is_pc_q) auto_pend_d = 1'b1;
                  else         state_d     = READER_ST_IDLE;
`else
                  state_d = READER_ST_IDLE;
`endif
                end
              end
            end
          end
          default: begin
            if (!empty) begin
              rd_ptr_d = rd_ptr_q + PROG_AW'(1);
              if (entry_cmd) begin
                case (entry_nib)
                  BUSCMD_LOAD_PC, BUSCMD_LOAD_DP: begin
                    strobe_d     = 1'b1;
                    cmd_data_d   = 1'b1;
                    bus_nibble_d = entry_nib;
                    state_d      = READER_ST_SEND_ADDR;
                    cnt_d        = '0;
`ifdef SATURN_BUS_AUTO_PC_READ_EN
                    is_pc_d      = (entry_nib == BUSCMD_LOAD_PC);
`endif
                  end
                  BUSCMD_PC_READ, BUSCMD_DP_READ: begin
                    strobe_d     = 1'b1;
                    cmd_data_d   = 1'b1;
                    bus_nibble_d = entry_nib;
                    state_d      = READER_ST_READ_STREAM;
                  end
                  BUSCMD_NOP: begin
                    strobe_d     = 1'b1;
                    cmd_data_d   = 1'b1;
                    bus_nibble_d = entry_nib;
                  end
                  default: begin
                    // unknown command is dropped rather than put on the bus
                    error_d = 1'b1;
                    state_d = READER_ST_IDLE;
                  end
                endcase
              end else begin
                // stray data entry outside an address phase
                error_d = 1'b1;
              end
            end else if (state_q == READER_ST_READ_STREAM && !i_no_read) begin
              strobe_d     = 1'b1;
              cmd_data_d   = 1'b0;
              bus_nibble_d = 4'h0;
              read_wait_d  = 1'b1;
            end
          end
        endcase
      end
      busy_d = (rd_ptr_d != i_program_address) || (state_d == READER_ST_SEND_ADDR) || strobe_d;
    end
  end

  // State and registered outputs; reset overrides clock enable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= READER_ST_IDLE;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      strobe_q     <= 1'b0;
      cmd_data_q   <= 1'b0;
      bus_nibble_q <= 4'h0;
      read_wait_q  <= 1'b0;
      nibble_q     <= 4'h0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SATURN_BUS_AUTO_PC_READ_EN
      is_pc_q      <= 1'b0;
      auto_pend_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      strobe_q     <= strobe_d;
      cmd_data_q   <= cmd_data_d;
      bus_nibble_q <= bus_nibble_d;
      read_wait_q  <= read_wait_d;
      nibble_q     <= nibble_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
`ifdef SATURN_BUS_AUTO_PC_READ_EN
      is_pc_q      <= is_pc_d;
      auto_pend_q  <= auto_pend_d;
`endif
    end
  end

  assign o_program_address = rd_ptr_q;
  assign o_bus_busy        = busy_q;
  assign o_bus_strobe      = strobe_q;
  assign o_bus_cmd_data    = cmd_data_q;
  assign o_bus_nibble      = bus_nibble_q;
  assign o_nibble          = nibble_q;
  assign o_nibble_valid    = valid_q;
  assign o_error           = error_q;

endmodule

// File: tb/tb_saturn_bus_program_reader.sv
// tb/tb_saturn_bus_program_reader.sv - scoreboard bench for the bus program reader
module tb_saturn_bus_program_reader;

  typedef struct {
    logic       cd;
    logic [3:0] n;
    logic       care;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [1:0]  ph = 2'd0;
  logic [3:0]  phases;
  logic [31:0] cyc = 32'd0;
  logic [4:0]  mem [32];
  logic [4:0]  wr_ptr;
  logic [4:0]  rd_ptr;
  logic [4:0]  prog_data;
  logic        no_read;
  logic        busy, strobe, cmd_data, nib_valid, err;
  logic [3:0]  bus_nib_o, bus_nib_i, nib;

  exp_t       exp_q[$];
  logic [3:0] exp_nib_q[$];
  logic [3:0] rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_strobe = 0;
  int n_valid  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    ph  <= ph + 2'd1;
    cyc <= cyc + 32'd1;
  end
  assign phases    = 4'b0001 << ph;
  assign prog_data = mem[rd_ptr];

  saturn_bus_program_reader dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_clk_en          (clk_en),
    .i_phases          (phases),
    .i_phase           (ph),
    .i_cycle_ctr       (cyc),
    .i_program_data    (prog_data),
    .i_program_address (wr_ptr),
    .o_program_address (rd_ptr),
    .i_no_read         (no_read),
    .o_bus_busy        (busy),
    .o_bus_strobe      (strobe),
    .o_bus_cmd_data    (cmd_data),
    .o_bus_nibble      (bus_nib_o),
    .i_bus_nibble      (bus_nib_i),
    .o_nibble          (nib),
    .o_nibble_valid    (nib_valid),
    .o_error           (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic push(input logic [4:0] e);
    mem[wr_ptr] = e;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic expect_strobe(input logic cd, input logic [3:0] n, input logic care);
    exp_t e;
    e.cd = cd; e.n = n; e.care = care;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_strobes(input int n, input string name);
    int target = n_strobe + n;
    for (int c = 0; c < 600 && n_strobe < target; c++) begin @(negedge clk); #1; end
    check(name, n_strobe >= target, 1);
  endtask

  task automatic wait_valids(input int n, input string name);
    int target = n_valid + n;
    for (int c = 0; c < 600 && n_valid < target; c++) begin @(negedge clk); #1; end
    check(name, n_valid >= target, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_ptr = 5'd0;
    exp_q.delete(); exp_nib_q.delete(); rsp_q.delete();
    idle(2);
    rst = 1'b0;
  endtask

  // Monitor: every strobe and every valid pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst && strobe) begin
      exp_t e;
      n_strobe++;
      check("strobe_busy", busy, 1);
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobe_cmd_data", cmd_data, e.cd);
        if (e.care) check("strobe_nibble", bus_nib_o, e.n);
      end
      if (!cmd_data && rsp_q.size() != 0) bus_nib_i = rsp_q.pop_front();
    end
    if (!rst && nib_valid) begin
      n_valid++;
      check("valid_expected", exp_nib_q.size() != 0, 1);
      if (exp_nib_q.size() != 0) check("read_nibble", nib, exp_nib_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int s, v;
    for (int i = 0; i < 32; i++) mem[i] = 5'h00;
    rst = 1'b1; clk_en = 1'b1; no_read = 1'b1; bus_nib_i = 4'h0; wr_ptr = 5'd0;
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_strobe", strobe, 0);
    check("rst_error", err, 0);
    check("rst_ptr", rd_ptr, 0);
    check("rst_valid", nib_valid, 0);
    check("rst_bus_word", {cmd_data, bus_nib_o, nib}, 0);
    rst = 1'b0;
    idle(1);

    // 1: LOAD_PC with five address nibbles
    push(5'h16); push(5'h05); push(5'h04); push(5'h03); push(5'h02); push(5'h01);
    expect_strobe(1, 4'h6, 1);
    for (int i = 5; i >= 1; i--) expect_strobe(0, 4'(i), 1);
`ifdef SATURN_BUS_AUTO_PC_READ_EN
    expect_strobe(1, 4'h2, 1);
    wait_strobes(3, "t1_first3");
    check("t1_busy_mid", busy, 1);
    wait_strobes(4, "t1_rest");
`else
    wait_strobes(3, "t1_first3");
    check("t1_busy_mid", busy, 1);
    wait_strobes(3, "t1_rest");
`endif
    idle(3);
    check("t1_busy_end", busy, 0);
    check("t1_drained", exp_q.size(), 0);

    // 2: PC_READ stream, two reads then no_read
    do_reset();
    push(5'h12);
    expect_strobe(1, 4'h2, 1);
    wait_strobes(1, "t2_cmd");
    rsp_q.push_back(4'hA); rsp_q.push_back(4'hB);
    exp_nib_q.push_back(4'hA); exp_nib_q.push_back(4'hB);
    expect_strobe(0, 4'h0, 0); expect_strobe(0, 4'h0, 0);
    no_read = 1'b0;
    wait_valids(2, "t2_valids");
    no_read = 1'b1;
    s = n_strobe; v = n_valid;
    idle(16);
    check("t2_noread_strobes", n_strobe, s);
    check("t2_noread_valids", n_valid, v);
    check("t2_busy_end", busy, 0);
    check("t2_drained", exp_q.size() + exp_nib_q.size(), 0);

    // 3: address stream stalls on an empty buffer
    do_reset();
    push(5'h16); push(5'h01); push(5'h02);
    expect_strobe(1, 4'h6, 1); expect_strobe(0, 4'h1, 1); expect_strobe(0, 4'h2, 1);
    wait_strobes(3, "t3_first");
    s = n_strobe;
    idle(12);
    check("t3_gap_strobes", n_strobe, s);
    check("t3_gap_busy", busy, 1);
    push(5'h03); push(5'h04); push(5'h05);
    expect_strobe(0, 4'h3, 1); expect_strobe(0, 4'h4, 1); expect_strobe(0, 4'h5, 1);
`ifdef SATURN_BUS_AUTO_PC_READ_EN
    expect_strobe(1, 4'h2, 1);
    wait_strobes(4, "t3_rest");
`else
    wait_strobes(3, "t3_rest");
`endif
    idle(3);
    check("t3_busy_end", busy, 0);
    check("t3_drained", exp_q.size(), 0);

    // 4: pointer wrap 30 -> 31 -> 0 -> 1
    do_reset();
    for (int i = 0; i < 30; i++) begin push(5'h10); expect_strobe(1, 4'h0, 1); end
    wait_strobes(30, "t4_nops");
    check("t4_ptr30", rd_ptr, 30);
    push(5'h17); push(5'h0A); push(5'h0B); push(5'h0C);
    expect_strobe(1, 4'h7, 1); expect_strobe(0, 4'hA, 1);
    expect_strobe(0, 4'hB, 1); expect_strobe(0, 4'hC, 1);
    wait_strobes(4, "t4_wrap");
    check("t4_ptr_wrapped", rd_ptr, 2);
    push(5'h0D); push(5'h0E);
    expect_strobe(0, 4'hD, 1); expect_strobe(0, 4'hE, 1);
    wait_strobes(2, "t4_finish");
    idle(3);
    check("t4_busy_end", busy, 0);
    check("t4_drained", exp_q.size(), 0);

    // 5: stray data and unknown command
    do_reset();
    s = n_strobe;
    push(5'h09);
    idle(8);
    check("t5_data_error", err, 1);
    check("t5_data_consumed", rd_ptr, 1);
    check("t5_data_nostrobe", n_strobe, s);
    push(5'h1F);
    idle(8);
    check("t5_cmd_error", err, 1);
    check("t5_cmd_consumed", rd_ptr, 2);
    check("t5_cmd_nostrobe", n_strobe, s);
    push(5'h10);
    expect_strobe(1, 4'h0, 1);
    wait_strobes(1, "t5_nop_after");
    idle(2);
    check("t5_error_sticky", err, 1);

    // 6: reset mid LOAD_PC address
    push(5'h16); push(5'h01); push(5'h02); push(5'h03);
    expect_strobe(1, 4'h6, 1); expect_strobe(0, 4'h1, 1); expect_strobe(0, 4'h2, 1);
    wait_strobes(3, "t6_before");
    rst = 1'b1;
    wr_ptr = 5'd0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk); #1;
    check("t6_strobe", strobe, 0);
    check("t6_busy", busy, 0);
    check("t6_error", err, 0);
    check("t6_ptr", rd_ptr, 0);
    check("t6_bus_word", {cmd_data, bus_nib_o}, 0);
    rst = 1'b0;
    idle(1);
    push(5'h10);
    expect_strobe(1, 4'h0, 1);
    wait_strobes(1, "t6_idle_nop");
    idle(2);
    check("t6_error_after", err, 0);
    check("t6_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
